tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

Round-robin arbiter that owns the shared tristate bus and generates the per-driver output enables feeding the tristate mux/driver stage. Up to N requesters contend for the bus. The arbiter issues exactly one registered, one-hot grant at a time and inserts a mandatory one-cycle turnaround between owners so that two drivers are never enabled in the same cycle. It sits directly upstream of the tristate drivers; its `grant` bits are their enables.

## Interface
- `N`, 4: number of requesters, legal range 2..16.
- `HOLD_MAX`, 8: maximum consecutive grant cycles per owner. Used only when `ARB_TIMEOUT_EN` is defined. Must be ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input N: request vector; `req[i]` high means driver i wants the bus.
- `grant` output N: registered one-hot enable for driver i, or all zero.
- `grant_id` output clog2(N): index of the current owner; holds the last owner when `grant` is zero.
- `bus_oe` output 1: OR of `grant`; high whenever some driver owns the bus.
- `preempt` output 1: one-cycle pulse when an owner is forcibly released.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: `grant` is nonzero.
  - TURN: one dead cycle, `grant` is zero.
- Arbitration happens in IDLE and TURN:
  - If `req` is nonzero, pick the winner by rotating priority starting at `last_id+1` (wrapping mod N).
  - Register `grant` to the winner's one-hot value, set `last_id` and `grant_id` to the winner, and move to GRANT.
  - If `req` is zero, go to IDLE.
- GRANT:
  - The owner keeps the bus while `req[grant_id]` stays high.
  - When `req[grant_id]` is sampled low, clear `grant` and go to TURN.
  - Requests from other drivers never preempt the owner (except through the timeout below).
- TURN lasts exactly one cycle. The next owner's grant appears in the cycle after TURN.
- Reset values: state IDLE; `grant`, `bus_oe` and `preempt` are 0; `grant_id` is 0; `last_id` is N-1, so requester 0 has first priority.
- Reset asserted during GRANT drops `grant` on the next edge, with no TURN cycle.
- A `req` bit for an index ≥ N does not exist. Requests that toggle during TURN are ignored until the arbitration at the end of TURN.

## Timing
- Latency from request to grant is 1 cycle. `req` sampled at edge k in IDLE gives `grant` valid after edge k.
- Release latency is 1 cycle. `req[owner]` sampled low at edge k clears `grant` after edge k.
- Back-to-back owners: old grant low at cycle k (TURN), new grant high at cycle k+1. There is exactly one dead cycle.
- If the releasing owner is the only requester, it re-requests and is regranted after TURN, because rotation wraps to it.
- `bus_oe` and `grant_id` are registered together with `grant`; there is no combinational path from `req` to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter of width clog2(HOLD_MAX+1) clears when entering GRANT and increments each GRANT cycle.
  - When the owner has held the bus for `HOLD_MAX` cycles, the owner is released regardless of `req`: `grant` clears, `preempt` pulses for that one cycle, and the arbiter goes to TURN.
- `ARB_TIMEOUT_EN` undefined: no counter exists, `preempt` is tied 0, and an owner holds the bus indefinitely.

## Structure
- Shared package `tristate_bus_pkg`: state encoding constants (IDLE=0, GRANT=1, TURN=2) and the state register width (2).
- Sub-module `rr_priority_pick`: combinational rotating-priority encoder.
  - Inputs: `req` and `last_id`.
  - Outputs: `winner_id` and `any_req`.
  - Instantiated once; holds no state.

## Test plan
Bench parameters: N=4, HOLD_MAX=4.
- Reset: hold `reset` for 2 cycles with `req`=1111 → `grant`=0000, `bus_oe`=0, `grant_id`=0, `preempt`=0 throughout.
- Single request: `req`=0010 at edge 0 → `grant`=0010, `grant_id`=1, `bus_oe`=1 after edge 0. Drop `req` at edge 3 → `grant`=0000 after edge 3, and stays IDLE.
- Contention: `req`=0101 from reset → `grant`=0001. Drop `req[0]` → one cycle of 0000, then `grant`=0100, `grant_id`=2.
- Rotation: with `last_id`=0, `req`=1001 from IDLE → `grant`=1000. After release, `req`=1001 → `grant`=0001.
- Timeout (macro on): `req`=0011 held → `grant`=0001 for 4 cycles, `preempt`=1 in the release cycle, one dead cycle, then `grant`=0010. With the macro off: `grant`=0001 indefinitely.
- Reset mid-grant: assert `reset` while `grant`=0100 → `grant`=0000 after the same edge. After deassert with `req`=0100 → `grant`=0100 one cycle later.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Shared types for the tristate bus arbiter: state encoding and helpers.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
package tristate_bus_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    function automatic int wrap_add(int a, int b, int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/tristate_bus_if.sv
// Request/grant bundle between the requesters and the bus arbiter.
// The master side is the arbiter; the slave side is the requester group.
interface tristate_bus_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          bus_oe;
    logic          preempt;

    modport master (
        input  req,
        output grant,
        output grant_id,
        output bus_oe,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  grant_id,
        input  bus_oe,
        input  preempt
    );

endinterface

// File: rtl/tristate_bus_arbiter_pick.sv
// Rotating-priority encoder: first requester after last_id, wrapping mod N.
// Purely combinational; the arbiter registers its result.
import tristate_bus_pkg::*;

module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_id,
    output logic [$clog2(N)-1:0] winner_id,
    output logic                 any_req
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Scan from lowest to highest priority so the nearest hit wins.
    always_comb begin
        winner_id = last_id;
        any_req   = 1'b0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'(wrap_add(int'(last_id), k, N));
            if (req[idx]) begin
                winner_id = idx;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin tristate bus arbiter with one dead cycle between owners.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
import tristate_bus_pkg::*;

module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input logic            clk,
    input logic            reset,
    tristate_bus_if.master bus
);
    localparam int IW = $clog2(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("N must be in 2..16");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("HOLD_MAX must be >= 1");
    end

    state_t        state;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] gid_q;
    logic [IW-1:0] last_q;
    logic          oe_q;
    logic [IW-1:0] win;
    logic          any;
    logic          owner_req;
    logic          expire;

    rr_priority_pick #(.N(N)) u_pick (
        .req       (bus.req),
        .last_id   (last_q),
        .winner_id (win),
        .any_req   (any)
    );

    assign owner_req = bus.req[gid_q];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_q;
    logic          pre_q;

    // Counter holds cycles already completed, so this is the last one.
    assign expire = (hold_q == HW'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            pre_q  <= 1'b0;
        end else begin
            pre_q <= 1'b0;
            if (state == S_GRANT) begin
                hold_q <= hold_q + HW'(1);
                if (expire && owner_req) begin
                    pre_q <= 1'b1;
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign bus.preempt = pre_q;
`else
    assign expire      = 1'b0;
    assign bus.preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IW'(N - 1);
            oe_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_TURN: begin
                    if (any) begin
                        grant_q <= N'(1) << win;
                        gid_q   <= win;
                        last_q  <= win;
                        oe_q    <= 1'b1;
                        state   <= S_GRANT;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (!owner_req || expire) begin
                        grant_q <= '0;
                        oe_q    <= 1'b0;
                        state   <= S_TURN;
                    end
                end
                default: begin
                    grant_q <= '0;
                    oe_q    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = gid_q;
    assign bus.bus_oe   = oe_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed plus random bench for tristate_bus_arbiter (N=4, HOLD_MAX=4)
// against an owner/last-winner reference model; honours ARB_TIMEOUT_EN.
module tb_tristate_bus_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    tristate_bus_if #(.N(N)) bus ();

    tristate_bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, who won last, how long held.
    int owner;
    int last;
    int gid;
    int held;
    bit pre;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] r, input bit rst);
        if (rst) begin
            owner = -1;
            last  = N - 1;
            gid   = 0;
            held  = 0;
            pre   = 1'b0;
        end else begin
            pre = 1'b0;
            if (owner >= 0) begin
                held++;
                if (!r[owner]) begin
                    owner = -1;
                end else if (TO_EN && held >= HOLD_MAX) begin
                    owner = -1;
                    pre   = 1'b1;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (owner < 0 && r[c]) begin
                        owner = c;
                    end
                end
                if (owner >= 0) begin
                    last = owner;
                    gid  = owner;
                    held = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit rst);
        logic [N-1:0] eg;
        @(negedge clk);
        bus.req = r;
        reset   = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
        eg = (owner >= 0) ? (N'(1) << owner) : '0;
        chk("grant",    32'(bus.grant),    32'(eg));
        chk("bus_oe",   32'(bus.bus_oe),   32'(owner >= 0));
        chk("grant_id", 32'(bus.grant_id), 32'(gid));
        chk("preempt",  32'(bus.preempt),  32'(pre));
    endtask

    initial begin
        logic [N-1:0] r;
        owner   = -1;
        last    = N - 1;
        gid     = 0;
        held    = 0;
        pre     = 1'b0;
        reset   = 1'b1;
        bus.req = '0;

        // Reset with every requester active.
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("rst_grant", 32'(bus.grant), 32'h0);

        // Single request, then release back to idle.
        step(4'b0010, 1'b0);
        chk("single_grant", 32'(bus.grant), 32'h2);
        chk("single_id", 32'(bus.grant_id), 32'h1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("single_rel", 32'(bus.grant), 32'h0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Contention from reset, with a single dead cycle at handover.
        step(4'b0000, 1'b1);
        step(4'b0101, 1'b0);
        chk("cont_first", 32'(bus.grant), 32'h1);
        step(4'b0101, 1'b0);
        step(4'b0100, 1'b0);
        chk("cont_dead", 32'(bus.grant), 32'h0);
        step(4'b0100, 1'b0);
        chk("cont_next", 32'(bus.grant), 32'h4);
        chk("cont_id", 32'(bus.grant_id), 32'h2);

        // Rotation after requester 0 has been served.
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1001, 1'b0);
        chk("rot_a", 32'(bus.grant), 32'h8);
        step(4'b0000, 1'b0);
        step(4'b1001, 1'b0);
        chk("rot_b", 32'(bus.grant), 32'h1);

        // Two requesters held steadily: timeout handover if enabled.
        step(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b0);

        // Reset during a grant drops it with no dead cycle.
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        chk("mid_pre", 32'(bus.grant), 32'h4);
        step(4'b0100, 1'b1);
        chk("mid_rst", 32'(bus.grant), 32'h0);
        step(4'b0100, 1'b0);
        chk("mid_post", 32'(bus.grant), 32'h4);

        // Random traffic with sticky requests and occasional resets.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            step(r, $urandom_range(0, 79) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
